// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the serializer and demultiplexer.
// Lane defaults, slot-width helper and the alignment state type.
package tdm_pkg;

  localparam int DEF_NCH   = 4;
  localparam int DEF_WIDTH = 1;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter for the TDM lane.
// Clear wins over load-to-1, load wins over increment.
module tdm_slot_counter #(
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] cnt
);

  // Slot index register; increment wraps naturally at 2**SW.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SW'(1);
    end else if (inc) begin
      cnt <= cnt + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer: slot alignment on Sync,
// shadow assembly and a registered parallel frame output.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      In,
  input  logic                  In_valid,
  input  logic                  Sync,
  output logic [NCH*WIDTH-1:0]  Out,
  output logic                  Out_valid,
  output logic [slot_w(NCH)-1:0] Sel,
  output logic                  Locked,
  output logic                  Err
);

  localparam int SW = slot_w(NCH);
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  state_t           state;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] shadow [NCH];

  logic c_clr;
  logic c_load;
  logic c_inc;
  logic in_lock;

  assign in_lock = In_valid && (state == LOCK);

  // Any accepted Sync starts a frame; a locked non-sync sample either
  // advances the slot or, at slot 0, drops the lock.
  assign c_load = In_valid && Sync;
  assign c_clr  = in_lock && !Sync && (cnt == '0);
  assign c_inc  = in_lock && !Sync && (cnt != '0);

  tdm_slot_counter #(
    .SW(SW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (c_clr),
    .load1(c_load),
    .inc  (c_inc),
    .cnt  (cnt)
  );

  assign Sel = cnt;

  // Alignment FSM with shadow buffer and registered frame/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      Locked    <= 1'b0;
      Out_valid <= 1'b0;
      Err       <= 1'b0;
      Out       <= '0;
      for (int k = 0; k < NCH; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      Out_valid <= 1'b0;
      Err       <= 1'b0;
      if (In_valid) begin
        unique case (state)
          HUNT: begin
            if (Sync) begin
              shadow[0] <= In;
              state     <= LOCK;
              Locked    <= 1'b1;
            end
          end
          LOCK: begin
            if (Sync) begin
              shadow[0] <= In;
              if (cnt != '0) begin
                Err <= 1'b1;
              end
            end else if (cnt == '0) begin
              Err    <= 1'b1;
              state  <= HUNT;
              Locked <= 1'b0;
            end else if (cnt == LAST) begin
              for (int k = 0; k < NCH - 1; k++) begin
                Out[k*WIDTH +: WIDTH] <= shadow[k];
              end
              Out[(NCH-1)*WIDTH +: WIDTH] <= In;
              Out_valid <= 1'b1;
            end else begin
              shadow[cnt] <= In;
            end
          end
          default: begin
            state  <= HUNT;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
